// File: rtl/fetch_queue.sv
// fetch_queue: instruction queue between fetch and decode.
// Captures {pc, instruction} pairs in a circular buffer and presents the oldest
// entry to decode in show-ahead form. Back-pressures fetch through in_ready.
// FLUSH discards every queued entry.
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   FLUSH            discard all entries (synchronous)
//   push             fetch presents in_instruction/in_pc this cycle
//   in_instruction   instruction word
//   in_pc            PC of in_instruction
//   in_ready         queue accepts a push this cycle
//   pop              decode consumes the head entry this cycle
//   out_valid        head entry is valid
//   out_instruction  head instruction (0 when empty)
//   out_pc           head PC (0 when empty)
//   count            occupied entries, 0..DEPTH
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     FLUSH,
  input  logic                     push,
  input  logic [WIDTH-1:0]         in_instruction,
  input  logic [WIDTH-1:0]         in_pc,
  output logic                     in_ready,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_instruction,
  output logic [WIDTH-1:0]         out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               wr_en;
  logic               rd_en;
  logic [2*WIDTH-1:0] head;

  // A full queue still accepts a push when decode pops in the same cycle.
  assign in_ready  = (count != CW'(DEPTH)) | pop;
  assign out_valid = (count != '0);

  assign wr_en = push & in_ready & ~FLUSH;
  assign rd_en = pop & out_valid & ~FLUSH;

  assign head            = mem[rd_ptr];
  assign out_pc          = out_valid ? head[2*WIDTH-1:WIDTH] : '0;
  assign out_instruction = out_valid ? head[WIDTH-1:0]       : '0;

  // Storage is never cleared; entries are invalidated by pointer/count state.
  always_ff @(posedge CLK) begin
    if (wr_en && !RST) begin
      mem[wr_ptr] <= {in_pc, in_instruction};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH=4, WIDTH=32).
// A scoreboard queue holds expected {pc, instruction} entries in FIFO order;
// entries are pushed when a push is predicted to be accepted and popped when
// decode consumes the head, which is compared against the front entry.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic              CLK;
  logic              RST;
  logic              FLUSH;
  logic              push;
  logic [WIDTH-1:0]  in_instruction;
  logic [WIDTH-1:0]  in_pc;
  logic              in_ready;
  logic              pop;
  logic              out_valid;
  logic [WIDTH-1:0]  out_instruction;
  logic [WIDTH-1:0]  out_pc;
  logic [2:0]        count;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .FLUSH           (FLUSH),
    .push            (push),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .in_ready        (in_ready),
    .pop             (pop),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .count           (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [63:0] sb [$];
  int unsigned n_cmp;
  int unsigned n_err;
  bit          armed;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle: apply inputs, check outputs against the model, update the
  // model as the DUT should on the coming edge, then advance past the edge.
  task automatic step(input bit p, input logic [31:0] pc, input logic [31:0] ins,
                      input bit po, input bit fl, input bit rs, input string tag);
    logic [63:0] exp_head;
    bit          exp_ready;
    bit          acc_w;
    bit          acc_r;
    push = p; in_pc = pc; in_instruction = ins; pop = po; FLUSH = fl; RST = rs;
    #1;
    exp_ready = (sb.size() != DEPTH) || po;
    exp_head  = (sb.size() != 0) ? sb[0] : 64'd0;
    if (armed) begin
      check({tag, ":count"},     64'(count),     64'(sb.size()));
      check({tag, ":out_valid"}, 64'(out_valid), 64'(sb.size() != 0));
      check({tag, ":in_ready"},  64'(in_ready),  64'(exp_ready));
      check({tag, ":head"},      {out_pc, out_instruction}, exp_head);
    end
    if (rs || fl) begin
      sb.delete();
    end else begin
      acc_w = p && exp_ready;
      acc_r = po && (sb.size() != 0);
      if (acc_r) void'(sb.pop_front());
      if (acc_w) sb.push_back({pc, ins});
    end
    if (rs) armed = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; armed = 1'b0;
    RST = 1'b0; FLUSH = 1'b0; push = 1'b0; pop = 1'b0;
    in_pc = '0; in_instruction = '0;
    @(posedge CLK);
    #1;

    // Reset, then fill
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, "reset");
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(i), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0, "fill");
    // Push into full queue without pop is dropped
    step(1'b1, 32'h77, 32'h77, 1'b0, 1'b0, 1'b0, "full_push");

    // Drain in order, plus a pop while empty
    for (int i = 0; i < 5; i++)
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, "drain");
    idle("empty");

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(i), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0, "refill");
    step(1'b1, 32'h10, 32'hB0, 1'b1, 1'b0, 1'b0, "full_pushpop");
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, "drain_b0");
    idle("empty2");

    // Wrap-around streaming at count=1
    step(1'b1, 32'h100, 32'h5100, 1'b0, 1'b0, 1'b0, "stream_seed");
    for (int i = 1; i <= 20; i++)
      step(1'b1, 32'h100 + 32'(i), 32'h5100 + 32'(i), 1'b1, 1'b0, 1'b0, "stream");
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, "stream_tail");

    // Flush collision
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h200 + 32'(i), 32'hE0 + 32'(i), 1'b0, 1'b0, 1'b0, "pre_flush");
    step(1'b1, 32'h2FF, 32'hD0, 1'b1, 1'b1, 1'b0, "flush");
    step(1'b1, 32'h300, 32'hC0, 1'b0, 1'b0, 1'b0, "post_flush");
    idle("post_flush_head");
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, "post_flush_pop");

    // Reset priority over flush/push/pop
    for (int i = 0; i < 2; i++)
      step(1'b1, 32'h400 + 32'(i), 32'hF0 + 32'(i), 1'b0, 1'b0, 1'b0, "pre_rst");
    step(1'b1, 32'h4FF, 32'hDD, 1'b1, 1'b1, 1'b1, "rst_all");
    step(1'b1, 32'h500, 32'h600, 1'b0, 1'b0, 1'b0, "after_rst");
    step(1'b1, 32'h501, 32'h601, 1'b1, 1'b0, 1'b0, "after_rst2");
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, "after_rst3");
    idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
